// File: rtl/write_back_seq.sv
// write_back_seq: write-back stage with GPR/R7 source muxing, valid/ready handshake and LM sequencer.
// Define WB_PERF_CNT_EN to add the wb_count write-cycle counter output.
module write_back_seq #(
    parameter int DATA_W     = 16,
    parameter int NUM_SRC    = 4,
    parameter int REG_SEL_W  = 2,
    parameter int NUM_R7_SRC = 6,
    parameter int R7_SEL_W   = 3,
    parameter int NUM_REGS   = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_SRC*DATA_W-1:0]      src_data,
    input  logic [REG_SEL_W-1:0]           reg_sel,
    input  logic [NUM_R7_SRC*DATA_W-1:0]   r7_src_data,
    input  logic [R7_SEL_W-1:0]            r7_sel,
    input  logic [ADDR_W-1:0]              rd,
    input  logic                           rf_we_req,
    input  logic                           r7_we_req,
    input  logic                           lm_en,
    input  logic [NUM_REGS-1:0]            lm_mask,
    input  logic                           beat_valid,
    input  logic [DATA_W-1:0]              beat_data,
    output logic                           rf_we,
    output logic [ADDR_W-1:0]              rf_waddr,
    output logic [DATA_W-1:0]              rf_wdata,
    output logic                           r7_we,
    output logic [DATA_W-1:0]              r7_wdata,
    output logic                           busy
`ifdef WB_PERF_CNT_EN
    ,
    output logic [15:0]                    wb_count
`endif
);
    typedef enum logic {IDLE, LM} state_t;
    localparam logic [ADDR_W-1:0] R7 = ADDR_W'(NUM_REGS - 1);
    state_t state_q, state_d;
    logic [NUM_REGS-1:0] mask_q, mask_d;
    logic rf_we_q, rf_we_d, r7_we_q, r7_we_d, to_r7;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d, lm_idx;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d, r7_wdata_q, r7_wdata_d, src_word, r7_word;

    // Out-of-range selects match no source and leave the word at zero.
    always_comb begin
        src_word = '0;
        r7_word = '0;
        lm_idx = '0;
        for (int k = 0; k < NUM_SRC; k++)
            if (k == int'(reg_sel)) src_word = src_data[k*DATA_W +: DATA_W];
        for (int k = 0; k < NUM_R7_SRC; k++)
            if (k == int'(r7_sel)) r7_word = r7_src_data[k*DATA_W +: DATA_W];
        for (int i = NUM_REGS - 1; i >= 0; i--)
            if (mask_q[i]) lm_idx = ADDR_W'(i);
    end

    always_comb begin
        state_d = state_q;
        mask_d = mask_q;
        rf_we_d = 1'b0;
        rf_waddr_d = '0;
        rf_wdata_d = '0;
        r7_we_d = 1'b0;
        r7_wdata_d = '0;
        to_r7 = rf_we_req && rd == R7;
        if (state_q == IDLE && in_valid && !lm_en) begin
            rf_we_d = rf_we_req && !to_r7;
            rf_waddr_d = rd;
            rf_wdata_d = src_word;
            r7_we_d = r7_we_req || to_r7;
            r7_wdata_d = r7_we_req ? r7_word : src_word;
        end else if (state_q == IDLE && in_valid && lm_mask != '0) begin
            mask_d = lm_mask;
            state_d = LM;
        end else if (state_q == LM && beat_valid) begin
            mask_d = mask_q & (mask_q - NUM_REGS'(1));
            rf_we_d = lm_idx != R7;
            r7_we_d = lm_idx == R7;
            rf_waddr_d = lm_idx;
            rf_wdata_d = beat_data;
            r7_wdata_d = beat_data;
            state_d = mask_d == '0 ? IDLE : LM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q <= '0;
            rf_we_q <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            r7_we_q <= 1'b0;
            r7_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            mask_q <= mask_d;
            rf_we_q <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            r7_we_q <= r7_we_d;
            r7_wdata_q <= r7_wdata_d;
        end
    end

    assign in_ready = state_q == IDLE;
    assign busy = state_q == LM;
    assign rf_we = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign r7_we = r7_we_q;
    assign r7_wdata = r7_wdata_q;

`ifdef WB_PERF_CNT_EN
    logic [15:0] cnt_q, cnt_d;
    always_comb cnt_d = cnt_q + 16'(rf_we_q | r7_we_q);
    always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
    assign wb_count = cnt_q;
`endif
endmodule

// File: tb/tb_write_back_seq.sv
// tb_write_back_seq: scoreboard bench for write_back_seq, built with NUM_SRC=3 to reach an out-of-range GPR select.
module tb_write_back_seq;
    typedef struct packed {
        logic        rf_we;
        logic [2:0]  rf_waddr;
        logic [15:0] rf_wdata;
        logic        r7_we;
        logic [15:0] r7_wdata;
        logic        in_ready;
        logic        busy;
        logic [15:0] cnt;
    } out_t;

    logic clk = 0, reset = 0, in_valid = 0, rf_we_req = 0, r7_we_req = 0, lm_en = 0, beat_valid = 0;
    logic [1:0] reg_sel = 0;
    logic [2:0] r7_sel = 0, rd = 0;
    logic [7:0] lm_mask = 0;
    logic [15:0] beat_data = 0;
    logic [15:0] src_w [3];
    logic [15:0] r7_w [6];
    logic [47:0] src_data;
    logic [95:0] r7_src_data;
    logic in_ready, rf_we, r7_we, busy;
    logic [2:0] rf_waddr;
    logic [15:0] rf_wdata, r7_wdata;
`ifdef WB_PERF_CNT_EN
    logic [15:0] wb_count;
`endif

    out_t exp_q[$], act_q[$];
    out_t mo = '0;
    logic m_lm = 0;
    logic [7:0] m_mask = 0;
    logic [15:0] m_cnt = 0;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < 3; k++) src_data[k*16 +: 16] = src_w[k];
        for (int k = 0; k < 6; k++) r7_src_data[k*16 +: 16] = r7_w[k];
    end

    write_back_seq #(.DATA_W(16), .NUM_SRC(3), .REG_SEL_W(2), .NUM_R7_SRC(6), .R7_SEL_W(3),
                     .NUM_REGS(8), .ADDR_W(3)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .src_data(src_data), .reg_sel(reg_sel), .r7_src_data(r7_src_data), .r7_sel(r7_sel),
        .rd(rd), .rf_we_req(rf_we_req), .r7_we_req(r7_we_req), .lm_en(lm_en), .lm_mask(lm_mask),
        .beat_valid(beat_valid), .beat_data(beat_data), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .r7_we(r7_we), .r7_wdata(r7_wdata), .busy(busy)
`ifdef WB_PERF_CNT_EN
        , .wb_count(wb_count)
`endif
    );

    // Predict the outputs after the coming edge, advance one cycle, then queue expected and observed.
    task automatic tick();
        out_t e, a;
        logic [15:0] s, r;
        int idx;
        e = '0;
`ifdef WB_PERF_CNT_EN
        e.cnt = reset ? 16'h0 : m_cnt + 16'(mo.rf_we | mo.r7_we);
`endif
        s = (reg_sel < 2'd3) ? src_w[reg_sel] : 16'h0;
        r = (r7_sel < 3'd6) ? r7_w[r7_sel] : 16'h0;
        if (reset) begin
            m_lm = 0;
            m_mask = 0;
        end else if (!m_lm && in_valid && !lm_en) begin
            e.rf_we = rf_we_req && rd != 3'd7;
            e.rf_waddr = rd;
            e.rf_wdata = s;
            e.r7_we = r7_we_req || (rf_we_req && rd == 3'd7);
            e.r7_wdata = r7_we_req ? r : s;
        end else if (!m_lm && in_valid && lm_mask != 0) begin
            m_lm = 1;
            m_mask = lm_mask;
        end else if (m_lm && beat_valid) begin
            idx = 0;
            for (int i = 0; i < 8; i++) if (m_mask[i]) begin idx = i; break; end
            m_mask[idx] = 1'b0;
            if (idx == 7) begin e.r7_we = 1; e.r7_wdata = beat_data; end
            else begin e.rf_we = 1; e.rf_waddr = 3'(idx); e.rf_wdata = beat_data; end
            if (m_mask == 0) m_lm = 0;
        end
        e.in_ready = !m_lm;
        e.busy = m_lm;
        mo = e;
        m_cnt = e.cnt;
        @(posedge clk);
        #1;
        a = '{rf_we, rf_waddr, rf_wdata, r7_we, r7_wdata, in_ready, busy, 16'h0};
`ifdef WB_PERF_CNT_EN
        a.cnt = wb_count;
`endif
        if (!e.rf_we) begin e.rf_waddr = 0; e.rf_wdata = 0; a.rf_waddr = 0; a.rf_wdata = 0; end
        if (!e.r7_we) begin e.r7_wdata = 0; a.r7_wdata = 0; end
        exp_q.push_back(e);
        act_q.push_back(a);
    endtask

    task automatic clear_in();
        in_valid = 0; rf_we_req = 0; r7_we_req = 0; lm_en = 0; lm_mask = 0; beat_valid = 0;
    endtask

    task automatic test_reset();
        out_t e, a;
        reset = 1;
        tick();
        tick();
        reset = 0;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, r7_we, r7_wdata, busy, in_ready} !== {38'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_raw got we=%b/%b addr=%h data=%h/%h busy=%b rdy=%b want zeros rdy=1",
                     rf_we, r7_we, rf_waddr, rf_wdata, r7_wdata, busy, in_ready);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL reset got %h want %h", a, e); end
        end
    endtask

    task automatic test_gpr_write();
        out_t e, a;
        src_w[1] = 16'h1234; reg_sel = 1; rd = 3; rf_we_req = 1; in_valid = 1;
        tick();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, r7_we} !== {1'b1, 3'd3, 16'h1234, 1'b0}) begin
            errors++;
            $display("FAIL gpr_raw got we=%b addr=%0d data=%h r7we=%b want 1 3 1234 0", rf_we, rf_waddr, rf_wdata, r7_we);
        end
        clear_in();
        tick();
        rd = 2; rf_we_req = 1; r7_we_req = 1; r7_sel = 4; r7_w[4] = 16'hBEEF; reg_sel = 0; in_valid = 1;
        tick();
        clear_in();
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL gpr got %h want %h", a, e); end
        end
    endtask

    task automatic test_r7_route();
        out_t e, a;
        rd = 7; rf_we_req = 1; r7_we_req = 1; r7_sel = 2; r7_w[2] = 16'h00A0; in_valid = 1;
        tick();
        checks++;
        if ({rf_we, r7_we, r7_wdata} !== {1'b0, 1'b1, 16'h00A0}) begin
            errors++;
            $display("FAIL r7_raw got rfwe=%b r7we=%b data=%h want 0 1 00a0", rf_we, r7_we, r7_wdata);
        end
        r7_we_req = 0; reg_sel = 2; src_w[2] = 16'h5A5A;
        tick();
        clear_in();
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL r7_route got %h want %h", a, e); end
        end
    endtask

    task automatic test_lm();
        out_t e, a;
        lm_en = 1; lm_mask = 8'b1000_0101; in_valid = 1; beat_valid = 1; beat_data = 16'hDEAD;
        tick();
        clear_in();
        beat_valid = 1; beat_data = 16'h0011;
        tick();
        beat_valid = 0; in_valid = 1; rf_we_req = 1; rd = 4;
        tick();
        in_valid = 0; rf_we_req = 0; beat_valid = 1; beat_data = 16'h0022;
        tick();
        beat_data = 16'h0033;
        tick();
        checks++;
        if ({r7_we, r7_wdata, rf_we, in_ready, busy} !== {1'b1, 16'h0033, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL lm_last got r7we=%b data=%h rfwe=%b rdy=%b busy=%b want 1 0033 0 1 0",
                     r7_we, r7_wdata, rf_we, in_ready, busy);
        end
        beat_data = 16'h0044;
        tick();
        clear_in();
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL lm got %h want %h", a, e); end
        end
    endtask

    task automatic test_lm_zero();
        out_t e, a;
        lm_en = 1; lm_mask = 0; in_valid = 1; rf_we_req = 1; r7_we_req = 1;
        tick();
        clear_in();
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL lm_zero got %h want %h", a, e); end
        end
    endtask

    task automatic test_out_of_range();
        out_t e, a;
        reg_sel = 3; rd = 5; rf_we_req = 1; r7_we_req = 1; r7_sel = 6; in_valid = 1;
        tick();
        checks++;
        if ({rf_we, rf_wdata, r7_we, r7_wdata} !== {1'b1, 16'h0, 1'b1, 16'h0}) begin
            errors++;
            $display("FAIL oor_raw got we=%b data=%h r7we=%b r7data=%h want 1 0 1 0", rf_we, rf_wdata, r7_we, r7_wdata);
        end
        r7_sel = 7;
        tick();
        clear_in();
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL out_of_range got %h want %h", a, e); end
        end
    endtask

    task automatic test_reset_in_lm();
        out_t e, a;
        lm_en = 1; lm_mask = 8'b0000_1110; in_valid = 1;
        tick();
        clear_in();
        beat_valid = 1; beat_data = 16'h0101;
        tick();
        reset = 1; beat_data = 16'h0202;
        tick();
        reset = 0; beat_data = 16'h0303;
        tick();
        tick();
        checks++;
        if ({rf_we, r7_we, in_ready, busy} !== 4'b0010) begin
            errors++;
            $display("FAIL reset_lm_raw got rfwe=%b r7we=%b rdy=%b busy=%b want 0 0 1 0", rf_we, r7_we, in_ready, busy);
        end
`ifdef WB_PERF_CNT_EN
        checks++;
        if (wb_count !== 16'h0) begin errors++; $display("FAIL reset_lm_cnt got %h want 0000", wb_count); end
`endif
        clear_in();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL reset_in_lm got %h want %h", a, e); end
        end
    endtask

    task automatic test_back_to_back();
        out_t e, a;
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 3; k++) src_w[k] = 16'($urandom);
            for (int k = 0; k < 6; k++) r7_w[k] = 16'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            reg_sel = 2'($urandom); r7_sel = 3'($urandom); rd = 3'($urandom);
            rf_we_req = 1'($urandom); r7_we_req = 1'($urandom);
            lm_en = ($urandom_range(0, 5) == 0); lm_mask = 8'($urandom);
            beat_valid = 1'($urandom); beat_data = 16'($urandom);
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end
        clear_in();
        reset = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL back_to_back got %h want %h", a, e); end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) src_w[k] = 16'h0;
        for (int k = 0; k < 6; k++) r7_w[k] = 16'h0;
        #2;
        test_reset();
        test_gpr_write();
        test_r7_route();
        test_lm();
        test_lm_zero();
        test_out_of_range();
        test_reset_in_lm();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
